// File: rtl/reg_file_param.sv
// Parametrised DEPTH x DATA_W register file: two combinational read ports, one write port,
// and a one-entry-per-cycle bulk-clear sweep. Optional write-through forwarding under `RF_BYPASS_EN.
module reg_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr1,
   input  logic [ADDR_W-1:0] i_rd_addr2,
   output logic [DATA_W-1:0] o_rd_data1,
   output logic [DATA_W-1:0] o_rd_data2,
   input  logic              i_clr_req,
   output logic              o_busy,
   output logic              o_clr_done,
   output logic              o_dbg_state,
   output logic [ADDR_W-1:0] o_dbg_ptr
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_done;
   logic              w_wr_fire;
   logic              w_sweep_last;
   logic [DATA_W-1:0] w_ent [DEPTH];
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   assign w_wr_fire    = i_wr_en && (r_state == S_IDLE);
   assign w_sweep_last = (r_state == S_CLEAR) && (r_ptr == '1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_sweep_last;
         if (r_state == S_CLEAR) begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_clr_req) w_next_state = S_CLEAR;
         S_CLEAR: if (w_sweep_last) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Entry 0 has no flop when ZERO_REG is set; the sweep still spends a cycle on it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
         assign w_ent[gi] = '0;
      end else begin : g_reg
         logic [DATA_W-1:0] r_q;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_q <= '0;
            end else if ((r_state == S_CLEAR) && (r_ptr == ADDR_W'(gi))) begin
               r_q <= '0;
            end else if (w_wr_fire && (i_wr_addr == ADDR_W'(gi))) begin
               r_q <= i_wr_data;
            end
         end
         assign w_ent[gi] = r_q;
      end
   end

`ifdef RF_BYPASS_EN
   logic w_zero_a1;
   logic w_zero_a2;
   assign w_zero_a1 = (ZERO_REG != 0) && (i_rd_addr1 == '0);
   assign w_zero_a2 = (ZERO_REG != 0) && (i_rd_addr2 == '0);
`endif

   always_comb begin
      w_rd1 = w_ent[i_rd_addr1];
      w_rd2 = w_ent[i_rd_addr2];
`ifdef RF_BYPASS_EN
      if (w_wr_fire && (i_rd_addr1 == i_wr_addr) && !w_zero_a1) w_rd1 = i_wr_data;
      if (w_wr_fire && (i_rd_addr2 == i_wr_addr) && !w_zero_a2) w_rd2 = i_wr_data;
`endif
   end

   assign o_rd_data1  = w_rd1;
   assign o_rd_data2  = w_rd2;
   assign o_busy      = (r_state == S_CLEAR);
   assign o_clr_done  = r_done;
   assign o_dbg_state = r_state;
   assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_reg_file_param.sv
// Random and directed stimulus on two reg_file_param instances (ZERO_REG=0 and ZERO_REG=1),
// checked against an array-based model through an expected-value queue.
module tb_reg_file_param;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic        clr;

  logic [15:0] n_rd1, n_rd2, z_rd1, z_rd2;
  logic        n_busy, n_done, z_busy, z_done;
  logic        n_st, z_st;
  logic [3:0]  n_ptr, z_ptr;

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
    .i_rd_addr1(ra1), .i_rd_addr2(ra2), .o_rd_data1(n_rd1), .o_rd_data2(n_rd2),
    .i_clr_req(clr), .o_busy(n_busy), .o_clr_done(n_done),
    .o_dbg_state(n_st), .o_dbg_ptr(n_ptr)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
    .i_rd_addr1(ra1), .i_rd_addr2(ra2), .o_rd_data1(z_rd1), .o_rd_data2(z_rd2),
    .i_clr_req(clr), .o_busy(z_busy), .o_clr_done(z_done),
    .o_dbg_state(z_st), .o_dbg_ptr(z_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents array plus remaining-sweep counter
  logic [15:0] mem [16];
  int          sweep_left;
  int          sweep_idx;
  logic        done_flag;

  logic [15:0] exp_q [$];
  int          errors;
  int          checks;
  int          pushed;

  function automatic logic [15:0] exp_rd(input bit zr, input logic [3:0] a);
    logic [15:0] v;
    v = mem[a];
    if (zr && a == 4'd0) v = 16'h0000;
`ifdef RF_BYPASS_EN
    if (we && sweep_left == 0 && a == wa && !(zr && a == 4'd0)) v = wd;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    sweep_left = 0;
    sweep_idx  = 0;
    done_flag  = 1'b0;
  endtask

  task automatic model_edge();
    logic nd;
    if (!rst_n) return;
    nd = (sweep_left == 1);
    if (sweep_left > 0) begin
      mem[sweep_idx] = 16'h0000;
      sweep_idx  = sweep_idx + 1;
      sweep_left = sweep_left - 1;
    end else begin
      if (we) mem[wa] = wd;
      if (clr) begin
        sweep_left = 16;
        sweep_idx  = 0;
      end
    end
    done_flag = nd;
  endtask

  task automatic push_expected();
    exp_q.push_back(exp_rd(1'b0, ra1));
    exp_q.push_back(exp_rd(1'b0, ra2));
    exp_q.push_back({15'd0, sweep_left > 0});
    exp_q.push_back({15'd0, done_flag});
    exp_q.push_back(exp_rd(1'b1, ra1));
    exp_q.push_back(exp_rd(1'b1, ra2));
    exp_q.push_back({15'd0, sweep_left > 0});
    exp_q.push_back({15'd0, done_flag});
    pushed = pushed + 8;
  endtask

  // driver: called at posedge+1, inputs settle, expectations queued, then the edge is modelled
  task automatic step(input logic w, input logic [3:0] a, input logic [15:0] d,
                      input logic [3:0] r1, input logic [3:0] r2, input logic c);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; clr = c;
    push_expected();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step_arst(input logic [3:0] r1, input logic [3:0] r2);
    we = 1'b0; clr = 1'b0; ra1 = r1; ra2 = r2;
    #2;
    rst_n = 1'b0;
    model_reset();
    push_expected();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares one cycle's worth of outputs at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() >= 8) begin
      logic [15:0] act [8];
      string       nm [8];
      act[0] = n_rd1; act[1] = n_rd2; act[2] = {15'd0, n_busy}; act[3] = {15'd0, n_done};
      act[4] = z_rd1; act[5] = z_rd2; act[6] = {15'd0, z_busy}; act[7] = {15'd0, z_done};
      nm[0] = "rd_data1"; nm[1] = "rd_data2"; nm[2] = "busy"; nm[3] = "clr_done";
      nm[4] = "zr_rd_data1"; nm[5] = "zr_rd_data2"; nm[6] = "zr_busy"; nm[7] = "zr_clr_done";
      for (int k = 0; k < 8; k++) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks = checks + 1;
        if (act[k] !== e) begin
          errors = errors + 1;
          $display("FAIL %s t=%0t ra1=%0d ra2=%0d got=%h want=%h", nm[k], $time, ra1, ra2, act[k], e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    pushed = 0;
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // reset state
    step(1'b0, 4'd0, 16'h0, 4'd0, 4'd15, 1'b0);
    step(1'b0, 4'd0, 16'h0, 4'd7, 4'd8, 1'b0);
    rst_n = 1'b1;
    // single write, same-cycle and next-cycle read
    step(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 1'b0);
    step(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0);
    step(1'b1, 4'd0, 16'h1234, 4'd0, 4'd1, 1'b0);
    step(1'b1, 4'd1, 16'h5678, 4'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 1'b0);
    // randomized traffic, occasional clears
    for (int i = 0; i < 80; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), a, 16'($urandom),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 1) ? a : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0));
    end
    while (sweep_left > 0) step(1'b0, 4'd0, 16'h0, 4'd3, 4'd12, 1'b0);
    // fill, then sweep with a refused write and a second clr_req
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'h1000 + 16'(i), 4'(i), 4'd12, 1'b0);
    step(1'b0, 4'd0, 16'h0, 4'd3, 4'd12, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step((i == 5), 4'd15, 16'hAAAA, (i < 8) ? 4'd3 : 4'(i), 4'd12, (i == 6));
    end
    step(1'b0, 4'd0, 16'h0, 4'd15, 4'd12, 1'b1);
    while (sweep_left > 0) step(1'b0, 4'd0, 16'h0, 4'd15, 4'd0, 1'b0);
    for (int i = 0; i < 16; i += 2) step(1'b0, 4'd0, 16'h0, 4'(i), 4'(i + 1), 1'b0);
    // async reset in the middle of a sweep
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'h2000 + 16'(i), 4'd9, 4'd14, 1'b0);
    step(1'b0, 4'd0, 16'h0, 4'd9, 4'd14, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0, 4'd9, 4'd14, 1'b0);
    step_arst(4'd9, 4'd14);
    step(1'b0, 4'd0, 16'h0, 4'd13, 4'd15, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 4'd1, 16'h00A1, 4'd1, 4'd2, 1'b0);
    step(1'b1, 4'd2, 16'h00A2, 4'd1, 4'd2, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL expected queue not drained: %0d left", exp_q.size());
    end
    if (checks != pushed) begin
      errors = errors + 1;
      $display("FAIL check count mismatch: did %0d, queued %0d", checks, pushed);
    end
    if (n_busy !== 1'b0 || z_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL busy still high at end: %b %b", n_busy, z_busy);
    end
    if (n_done !== 1'b0 || z_done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL clr_done high at end: %b %b", n_done, z_done);
    end
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
